// File: rtl/bd_rx_buffer.sv
// BD pin receiver: synchronised four-phase capture into a show-ahead FIFO.
// Optional 16-bit saturating capture counter with BD_RX_COUNT_EN.
module bd_rx_buffer #(
  parameter int NUM_BITS    = 34,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    _Reset,
  input  logic [NUM_BITS-1:0]     bd_data,
  input  logic                    bd_valid_n,
  output logic                    bd_ready,
  output logic [NUM_BITS-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level
`ifdef BD_RX_COUNT_EN
  ,
  output logic [15:0]             word_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    RELEASE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SYNC_STAGES-1:0] vsync;
  logic                   vs_n;
  logic [NUM_BITS-1:0]    mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic [LW-1:0]          level_nx;

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      vsync <= '1;
    end else begin
      vsync <= {vsync[SYNC_STAGES-2:0], bd_valid_n};
    end
  end

  assign vs_n      = vsync[SYNC_STAGES-1];
  assign full      = (level == FULL_LVL);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!vs_n && !full) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        push     = 1'b1;
        state_nx = RELEASE;
      end
      RELEASE: begin
        if (vs_n) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    level_nx = level;
    unique case ({push, pop})
      2'b10:   level_nx = level + 1'b1;
      2'b01:   level_nx = level - 1'b1;
      default: level_nx = level;
    endcase
  end

  // ready looks one edge ahead so it is valid the cycle IDLE is entered
  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      state    <= IDLE;
      level    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      bd_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      level    <= level_nx;
      bd_ready <= (state_nx == IDLE) && (level_nx != FULL_LVL);
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bd_data;
    end
  end

`ifdef BD_RX_COUNT_EN
  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      word_count <= '0;
    end else if (push && (word_count != 16'hFFFF)) begin
      word_count <= word_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bd_rx_buffer.sv
// Bench for bd_rx_buffer: vector table plus scoreboard of captured words.
// Popped words are compared against the queue as they leave the FIFO.
module tb_bd_rx_buffer;

  localparam int NB = 34;
  localparam int DP = 8;
  localparam int SS = 2;

  logic          clk;
  logic          _Reset;
  logic [NB-1:0] bd_data;
  logic          bd_valid_n;
  logic          bd_ready;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
`ifdef BD_RX_COUNT_EN
  logic [15:0]   word_count;
`endif

  bd_rx_buffer #(
    .NUM_BITS(NB),
    .DEPTH(DP),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    ._Reset(_Reset),
    .bd_data(bd_data),
    .bd_valid_n(bd_valid_n),
    .bd_ready(bd_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level)
`ifdef BD_RX_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] data;
    int            hold;
    int            exp_level;
    logic [NB-1:0] exp_head;
    logic          exp_rdy;
  } vec_t;

  int            checks;
  int            failures;
  int            cap_cnt;
  int            maxlvl;
  logic [NB-1:0] sb[$];
  vec_t          vecs[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (_Reset) begin
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_extra: got %0h expected none", out_data);
        end else begin
          chk("pop_data", 64'(out_data), 64'(sb.pop_front()));
        end
      end
    end
  end

  task automatic wait_fall(output bit ok);
    int n;
    n = 0;
    while (bd_ready && n < 50) begin
      tick();
      n++;
    end
    ok = !bd_ready;
  endtask

  task automatic bd_send(input logic [NB-1:0] d, input int hold,
                         output bit ok);
    int n;
    bit f;
    n = 0;
    while (!bd_ready && n < 300) begin
      tick();
      n++;
    end
    ok = bd_ready;
    if (ok) begin
      bd_data    = d;
      bd_valid_n = 1'b0;
      wait_fall(f);
      ok = f;
      if (f) begin
        sb.push_back(d);
        cap_cnt++;
      end
      repeat (hold) tick();
      chk("rdy_low_hold", 64'(bd_ready), 64'(0));
      bd_valid_n = 1'b1;
      repeat (SS + 3) tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (level != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_level", 64'(level), 64'(0));
    chk("drain_sb", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    bit ok;
    bit ok9;
    bit allok;

    for (int i = 0; i < 8; i++) begin
      vecs[i].data      = NB'(i + 1);
      vecs[i].hold      = i + 1;
      vecs[i].exp_level = i + 1;
      vecs[i].exp_head  = NB'(1);
      vecs[i].exp_rdy   = (i < 7);
    end

    checks     = 0;
    failures   = 0;
    cap_cnt    = 0;
    maxlvl     = 0;
    _Reset     = 1'b0;
    bd_valid_n = 1'b1;
    bd_data    = '0;
    out_ready  = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 64'(bd_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    _Reset = 1'b1;
    repeat (2) tick();

    out_ready = 1'b1;
    repeat (4) tick();
    chk("empty_level", 64'(level), 64'(0));
    chk("empty_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    bd_data    = NB'(34'h1234);
    bd_valid_n = 1'b0;
    repeat (SS + 1) tick();
    chk("lat_before", 64'(out_valid), 64'(0));
    chk("lat_rdy_low", 64'(bd_ready), 64'(0));
    tick();
    chk("lat_push", 64'(out_valid), 64'(1));
    sb.push_back(NB'(34'h1234));
    cap_cnt++;
    bd_valid_n = 1'b1;
    repeat (SS + 3) tick();
    chk("lat_level", 64'(level), 64'(1));
    drain();

    bd_send(34'h2_DEAD_BEEF, 6, ok);
    chk("single_ok", 64'(ok), 64'(1));
    chk("single_level", 64'(level), 64'(1));
    chk("single_data", 64'(out_data), 64'h2_DEAD_BEEF);
    chk("single_rdy", 64'(bd_ready), 64'(1));
    drain();

    foreach (vecs[i]) begin
      bd_send(vecs[i].data, vecs[i].hold, ok);
      chk("fill_ok", 64'(ok), 64'(1));
      chk("fill_level", 64'(level), 64'(vecs[i].exp_level));
      chk("fill_head", 64'(out_data), 64'(vecs[i].exp_head));
      chk("fill_rdy", 64'(bd_ready), 64'(vecs[i].exp_rdy));
    end

    fork
      bd_send(NB'(9), 2, ok9);
      begin
        repeat (6) tick();
        chk("held_level", 64'(level), 64'(8));
        chk("held_rdy", 64'(bd_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    join
    chk("w9_ok", 64'(ok9), 64'(1));
    chk("w9_level", 64'(level), 64'(8));
    chk("w9_head", 64'(out_data), 64'(2));
    drain();

    bd_send(NB'(34'h100), 1, ok);
    bd_send(NB'(34'h101), 1, ok);
    bd_send(NB'(34'h102), 1, ok);
    chk("sim_pre", 64'(level), 64'(3));
    bd_data    = NB'(34'h103);
    bd_valid_n = 1'b0;
    wait_fall(ok);
    chk("sim_fall", 64'(ok), 64'(1));
    sb.push_back(NB'(34'h103));
    cap_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sim_level", 64'(level), 64'(3));
    chk("sim_head", 64'(out_data), 64'h101);
    bd_valid_n = 1'b1;
    repeat (SS + 3) tick();
    drain();

    maxlvl    = 0;
    allok     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bd_send(NB'(i), 1, ok);
      allok &= ok;
    end
    repeat (4) tick();
    out_ready = 1'b0;
    chk("wrap_ok", 64'(allok), 64'(1));
    chk("wrap_maxlvl", 64'(maxlvl <= 2), 64'(1));
    chk("wrap_level", 64'(level), 64'(0));
    chk("wrap_sb", 64'(sb.size()), 64'(0));

    for (int i = 0; i < 4; i++) begin
      bd_send(NB'(34'h200 + i), 1, ok);
    end
    bd_data    = NB'(34'h204);
    bd_valid_n = 1'b0;
    wait_fall(ok);
    tick();
    chk("mid_level", 64'(level), 64'(5));
    _Reset = 1'b0;
    #1;
    chk("mid_valid", 64'(out_valid), 64'(0));
    chk("mid_lvl0", 64'(level), 64'(0));
    chk("mid_rdy", 64'(bd_ready), 64'(1));
    sb.delete();
    cap_cnt = 0;
    bd_data = NB'(34'h3_0000_0055);
    #1;
    _Reset  = 1'b1;
    repeat (SS + 1) tick();
    chk("rel_before", 64'(level), 64'(0));
    tick();
    chk("rel_push", 64'(level), 64'(1));
    chk("rel_data", 64'(out_data), 64'h3_0000_0055);
    sb.push_back(NB'(34'h3_0000_0055));
    cap_cnt++;
    bd_valid_n = 1'b1;
    repeat (SS + 3) tick();
    bd_send(NB'(34'h77), 2, ok);
    chk("after_ok", 64'(ok), 64'(1));
    chk("after_level", 64'(level), 64'(2));
`ifdef BD_RX_COUNT_EN
    chk("word_count", 64'(word_count), 64'(cap_cnt));
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bd_rx_buffer.md
BD_RX_BUFFER -- requirements
Module: bd_rx_buffer

Interface
REQ-001 Parameter NUM_BITS, default 34: width of one BD core-to-pin word.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, minimum 2.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops on bd_valid_n; minimum 2.
REQ-004 clk  input  1  FPGA system clock; all state on rising edge.
REQ-005 _Reset  input  1  reset, asynchronous, active-low.
REQ-006 bd_data  input  NUM_BITS  word from BD pins; held stable by BD while bd_valid_n is low.
REQ-007 bd_valid_n  input  1  BD valid, active-low, asynchronous to clk.
REQ-008 bd_ready  output  1  FPGA ready to BD, active-high, registered.
REQ-009 out_data  output  NUM_BITS  FIFO head word (show-ahead).
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  downstream accept; pop when out_valid and out_ready are both high.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 bd_valid_n passes through SYNC_STAGES flops reset to 1; the FSM uses only the synchronized value vs_n.
REQ-014 FSM states: IDLE, CAPTURE, RELEASE.
- IDLE: bd_ready=1 iff level<DEPTH; go to CAPTURE when vs_n=0 and level<DEPTH.
- CAPTURE: one cycle; push bd_data into FIFO; bd_ready=0; go to RELEASE.
- RELEASE: bd_ready=0; go to IDLE when vs_n=1.
REQ-015 This is a four-phase handshake; exactly one word is captured per low pulse of bd_valid_n, however long the pulse lasts.
REQ-016 Latency: bd_valid_n sampled low at edge k gives the CAPTURE push at edge k+SYNC_STAGES+1; out_valid rises after that edge when the FIFO was empty.
REQ-017 bd_ready falls after the edge that enters CAPTURE; it rises after the edge that enters IDLE, provided level<DEPTH.
REQ-018 Full FIFO: the FSM holds in IDLE with bd_ready=0 while vs_n is ignored; on the first pop it asserts bd_ready on the next edge and may capture after that.
REQ-019 Empty FIFO: out_valid=0; out_ready is ignored; no pointer or level change; out_data is don't-care.
REQ-020 Push and pop on the same edge: level unchanged; both pointers advance.
REQ-021 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; level is computed without overflow in the range 0..DEPTH.
REQ-022 out_data, out_valid and level are registered or driven directly from registered state; there is no combinational path from bd_* or out_ready to any output.

Reset
REQ-023 While _Reset=0, the following hold:
- FSM=IDLE; pointers=0; level=0.
- out_valid=0; bd_ready=1.
- sync flops=1; out_data=0.
REQ-024 Reset asserted mid-operation discards all stored words and any in-flight capture; release proceeds from IDLE.
REQ-025 If bd_valid_n is low at reset release, capture happens SYNC_STAGES+1 edges later.

Configuration
REQ-026 Macro BD_RX_COUNT_EN:
- Defined: adds output word_count (16 bits); it increments on every CAPTURE push, saturates at 0xFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-027 Single word: bd_data=0x2_DEAD_BEEF, bd_valid_n pulsed low 6 cycles, out_ready=0 -> exactly one push; out_data=0x2_DEAD_BEEF; level=1; bd_ready low from CAPTURE until vs_n returns high.
REQ-028 Fill: 9 handshakes with words 1..9, out_ready=0 -> level=8, bd_ready=0; word 9 is held at the BD. Then one pop -> out_data=1 removed; word 9 captured; FIFO reads 2..9 in order.
REQ-029 Simultaneous: level=3 and out_ready=1 on the CAPTURE edge -> level stays 3; head advances.
REQ-030 Wrap: 20 words 0..19 streamed with out_ready=1 -> all delivered in order; pointers wrap twice; level never exceeds 2.
REQ-031 Reset mid-op: level=5 and FSM in RELEASE, _Reset pulsed low -> out_valid=0, level=0, bd_ready=1 immediately; next handshake captured normally.
REQ-032 BD_RX_COUNT_EN defined: 70000 handshakes -> word_count=0xFFFF; reset -> 0.
